// File: rtl/mem_byte_master_if.sv
// Byte-wide request/valid bus between mem_byte_master and cache memory Port A.
interface mem_byte_master_if #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] o_mem_address;
   logic [DATA_WIDTH-1:0] o_mem_data;
   logic                  o_mem_write;
   logic                  o_mem_request;
   logic [DATA_WIDTH-1:0] i_mem_data;
   logic                  i_mem_data_DV;

   modport master (
      output o_mem_address, o_mem_data, o_mem_write, o_mem_request,
      input  i_mem_data, i_mem_data_DV
   );

   modport slave (
      input  o_mem_address, o_mem_data, o_mem_write, o_mem_request,
      output i_mem_data, i_mem_data_DV
   );
endinterface

// File: rtl/mem_byte_master.sv
// Splits one CPU byte/halfword/word load or store into single-byte memory
// requests, assembles read bytes little-endian and sign/zero extends loads.
module mem_byte_master #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_busy,
   output logic        o_done,
   mem_byte_master_if.master mem
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t                      state_q, state_d;
   logic                        we_q, we_d;
   logic                        uns_q, uns_d;
   logic [3:0][DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [3:0][DATA_WIDTH-1:0]  buf_q, buf_d;
   logic [ADDR_WIDTH-1:0]       base_q, base_d;
   logic [2:0]                  nbytes_q, nbytes_d;
   logic [1:0]                  cnt_q, cnt_d;
   logic [31:0]                 rdata_q, rdata_d;
   logic [31:0]                 ext;

   // CPU address bits above the memory width are deliberately dropped
   logic unused_addr_bits;
   assign unused_addr_bits = ^i_addr[31:ADDR_WIDTH];

   assign o_rdata = rdata_q;
   assign o_busy  = (state_q != S_IDLE);

   // Next-state, command latching, byte assembly and state-decoded bus outputs
   always_comb begin
      state_d           = state_q;
      we_d              = we_q;
      uns_d             = uns_q;
      wdata_d           = wdata_q;
      buf_d             = buf_q;
      base_d            = base_q;
      nbytes_d          = nbytes_q;
      cnt_d             = cnt_q;
      rdata_d           = rdata_q;
      o_done            = 1'b0;
      mem.o_mem_request = 1'b0;
      mem.o_mem_write   = 1'b0;
      mem.o_mem_address = '0;
      mem.o_mem_data    = '0;

      case (nbytes_q)
         3'd1:    ext = {{24{~uns_q & buf_q[0][DATA_WIDTH-1]}}, buf_q[0]};
         3'd2:    ext = {{16{~uns_q & buf_q[1][DATA_WIDTH-1]}}, buf_q[1], buf_q[0]};
         default: ext = buf_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               we_d     = i_we;
               uns_d    = i_unsigned;
               wdata_d  = i_wdata;
               base_d   = i_addr[ADDR_WIDTH-1:0];
               nbytes_d = (i_size == 2'd0) ? 3'd1 : (i_size == 2'd1) ? 3'd2 : 3'd4;
               cnt_d    = 2'd0;
               buf_d    = '0;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mem.o_mem_request = 1'b1;
            mem.o_mem_write   = we_q;
            mem.o_mem_address = base_q + ADDR_WIDTH'(cnt_q);
            mem.o_mem_data    = wdata_q[cnt_q];
            state_d           = S_WAIT;
         end
         S_WAIT: begin
            if (mem.i_mem_data_DV) begin
               if (!we_q) buf_d[cnt_q] = mem.i_mem_data;
               if ({1'b0, cnt_q} == nbytes_q - 3'd1) begin
                  state_d = S_DONE;
               end else begin
                  cnt_d   = cnt_q + 2'd1;
                  state_d = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            o_done  = 1'b1;
            if (!we_q) rdata_d = ext;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         uns_q    <= 1'b0;
         wdata_q  <= '0;
         buf_q    <= '0;
         base_q   <= '0;
         nbytes_q <= '0;
         cnt_q    <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         uns_q    <= uns_d;
         wdata_q  <= wdata_d;
         buf_q    <= buf_d;
         base_q   <= base_d;
         nbytes_q <= nbytes_d;
         cnt_q    <= cnt_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_byte_master.sv
// Directed self-checking bench for mem_byte_master with a one-cycle-latency
// byte memory model on the bus.
module tb_mem_byte_master;

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_start = 1'b0;
   logic        i_we = 1'b0;
   logic [1:0]  i_size = 2'd0;
   logic        i_unsigned = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_wdata = '0;
   logic [31:0] o_rdata;
   logic        o_busy;
   logic        o_done;

   mem_byte_master_if #(.ADDR_WIDTH(14), .DATA_WIDTH(8)) bus ();

   mem_byte_master #(.ADDR_WIDTH(14), .DATA_WIDTH(8)) dut (
      .i_clk      (clk),
      .i_reset    (i_reset),
      .i_start    (i_start),
      .i_we       (i_we),
      .i_size     (i_size),
      .i_unsigned (i_unsigned),
      .i_addr     (i_addr),
      .i_wdata    (i_wdata),
      .o_rdata    (o_rdata),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .mem        (bus)
   );

   always #5 clk = ~clk;

   // Memory model: request in cycle k, DV (and read data) in cycle k+1
   logic [7:0]  mem [0:16383];
   logic        pk_en = 1'b0;
   logic [13:0] pk_a = '0;
   logic [7:0]  pk_d = '0;

   always @(posedge clk) begin
      bus.i_mem_data_DV <= 1'b0;
      if (pk_en) mem[pk_a] <= pk_d;
      if (bus.o_mem_request) begin
         if (bus.o_mem_write) mem[bus.o_mem_address] <= bus.o_mem_data;
         else                 bus.i_mem_data <= mem[bus.o_mem_address];
         bus.i_mem_data_DV <= 1'b1;
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic poke(input logic [13:0] a, input logic [7:0] d);
      pk_en = 1'b1; pk_a = a; pk_d = d;
      @(negedge clk);
      pk_en = 1'b0;
   endtask

   int          req_cyc [$];
   logic [13:0] req_adr [$];
   logic [7:0]  req_dat [$];
   logic        req_wr  [$];
   int          done_cyc, ndone, b2b, busy_cnt;

   // Start a command in cycle 0 and watch ncyc cycles; optionally a second
   // i_start (store byte 0x77 to 0x40) and/or a reset in given cycles.
   task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int start2_at, input int rst_at, input int ncyc);
      logic prev_req;
      req_cyc.delete(); req_adr.delete(); req_dat.delete(); req_wr.delete();
      done_cyc = -1; ndone = 0; b2b = 0; busy_cnt = 0; prev_req = 1'b0;
      @(negedge clk);
      i_start = 1'b1; i_we = we; i_size = sz; i_unsigned = uns;
      i_addr = addr; i_wdata = wdata;
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (bus.o_mem_request) begin
            req_cyc.push_back(k);
            req_adr.push_back(bus.o_mem_address);
            req_dat.push_back(bus.o_mem_data);
            req_wr.push_back(bus.o_mem_write);
            if (prev_req) b2b++;
         end
         prev_req = bus.o_mem_request;
         if (o_done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = k;
         end
         if (o_busy) busy_cnt++;
         i_start = 1'b0;
         i_reset = 1'b0;
         if (k == start2_at) begin
            i_start = 1'b1; i_we = 1'b1; i_size = 2'd0;
            i_addr = 32'h40; i_wdata = 32'h77;
         end
         if (k == rst_at) i_reset = 1'b1;
      end
      i_start = 1'b0;
      i_reset = 1'b0;
   endtask

   initial begin
      logic [7:0] st_bytes [4];
      st_bytes[0] = 8'hEF; st_bytes[1] = 8'hBE; st_bytes[2] = 8'hAD; st_bytes[3] = 8'hDE;

      // Reset held while the memory is preloaded
      @(negedge clk);
      poke(14'h0020, 8'h80);
      poke(14'h3FFF, 8'h34);
      poke(14'h0000, 8'h92);
      poke(14'h0040, 8'h55);
      poke(14'h0052, 8'hAA);
      poke(14'h0053, 8'hAA);
      check("rst_rdata", o_rdata, 32'h0);
      check("rst_busy",  {31'b0, o_busy}, 32'h0);
      check("rst_done",  {31'b0, o_done}, 32'h0);
      check("rst_req",   {31'b0, bus.o_mem_request}, 32'h0);
      check("rst_write", {31'b0, bus.o_mem_write}, 32'h0);
      check("rst_addr",  {18'b0, bus.o_mem_address}, 32'h0);
      check("rst_wdat",  {24'b0, bus.o_mem_data}, 32'h0);
      i_reset = 1'b0;

      // Word store 0xDEADBEEF to 0x10
      run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, -1, -1, 12);
      check("st_nreq", req_cyc.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < req_cyc.size()) begin
            check($sformatf("st_cyc%0d", i), req_cyc[i], 1 + 2 * i);
            check($sformatf("st_adr%0d", i), {18'b0, req_adr[i]}, 32'h10 + i);
            check($sformatf("st_dat%0d", i), {24'b0, req_dat[i]}, {24'b0, st_bytes[i]});
            check($sformatf("st_wr%0d", i), {31'b0, req_wr[i]}, 32'h1);
         end
         check($sformatf("st_mem%0d", i), {24'b0, mem[14'h10 + 14'(i)]}, {24'b0, st_bytes[i]});
      end
      check("st_done_cyc", done_cyc, 9);
      check("st_ndone", ndone, 1);
      check("st_busy", busy_cnt, 9);
      check("st_b2b", b2b, 0);
      check("st_rdata_kept", o_rdata, 32'h0);

      // Byte loads from 0x20 holding 0x80
      run(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, -1, -1, 6);
      check("lb_s_rdata", o_rdata, 32'hFFFFFF80);
      check("lb_s_done", done_cyc, 3);
      check("lb_s_busy", busy_cnt, 3);
      run(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, -1, -1, 6);
      check("lb_u_rdata", o_rdata, 32'h00000080);
      check("lb_u_done", done_cyc, 3);

      // Halfword load wrapping at the top of memory
      run(1'b0, 2'd1, 1'b0, 32'h3FFF, 32'h0, -1, -1, 8);
      check("wrap_nreq", req_cyc.size(), 2);
      if (req_adr.size() == 2) begin
         check("wrap_adr0", {18'b0, req_adr[0]}, 32'h3FFF);
         check("wrap_adr1", {18'b0, req_adr[1]}, 32'h0000);
         check("wrap_wr0", {31'b0, req_wr[0]}, 32'h0);
      end
      check("wrap_rdata", o_rdata, 32'hFFFF9234);
      check("wrap_done", done_cyc, 5);

      // Word load passes through; misaligned unsigned halfword zero-extends
      run(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, -1, -1, 11);
      check("lw_rdata", o_rdata, 32'hDEADBEEF);
      check("lw_done", done_cyc, 9);
      check("lw_b2b", b2b, 0);
      run(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, -1, -1, 8);
      check("lhu_rdata", o_rdata, 32'h0000ADBE);
      check("lhu_done", done_cyc, 5);

      // i_start while busy is ignored
      run(1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 2, -1, 10);
      check("busy_ndone", ndone, 1);
      check("busy_done", done_cyc, 3);
      check("busy_nreq", req_cyc.size(), 1);
      check("busy_mem40", {24'b0, mem[14'h40]}, 32'h55);
      check("busy_rdata", o_rdata, 32'hFFFFFF80);

      // Reset in cycle 4 of a word store
      run(1'b1, 2'd2, 1'b0, 32'h50, 32'h11223344, -1, 4, 12);
      check("rstm_ndone", ndone, 0);
      check("rstm_nreq", req_cyc.size(), 2);
      if (req_cyc.size() > 0) check("rstm_last_req", req_cyc[req_cyc.size() - 1], 3);
      check("rstm_mem50", {24'b0, mem[14'h50]}, 32'h44);
      check("rstm_mem51", {24'b0, mem[14'h51]}, 32'h33);
      check("rstm_mem52", {24'b0, mem[14'h52]}, 32'hAA);
      check("rstm_mem53", {24'b0, mem[14'h53]}, 32'hAA);
      check("rstm_rdata", o_rdata, 32'h0);
      check("rstm_busy", {31'b0, o_busy}, 32'h0);

      // Normal byte load after the aborted store
      run(1'b0, 2'd0, 1'b1, 32'h51, 32'h0, -1, -1, 6);
      check("post_rdata", o_rdata, 32'h00000033);
      check("post_done", done_cyc, 3);
      check("post_ndone", ndone, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
